imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares the single-port 64K x 16 on-chip memory between the instruction-fetch port (read-only) and the data port (read/write) of the multicycle core.
- Issues at most one access per cycle.
- Arbitrates round-robin, with a lock that lets the data port keep the memory for load-multiple and store-multiple bursts.
- Steers the one-cycle-latency read data back to the port that issued the read.
- Sits between the core and the memory's Avalon slave signals.

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 16, data width.
- BE_W, 2, byte-enable width (DATA_W/8).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- freeze  in  1  when high, no new grants are made; accesses already in flight complete.
- if_req  in  1  fetch port read request.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rdata  out  DATA_W  fetch read data.
- if_rvalid  out  1  if_rdata valid.
- d_req  in  1  data port request.
- d_we  in  1  1 = write, 0 = read.
- d_lock  in  1  hold the data-port grant across consecutive requests.
- d_addr  in  ADDR_W  data word address.
- d_be  in  BE_W  data byte enables (writes only).
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rdata  out  DATA_W  data read data.
- d_rvalid  out  1  d_rdata valid.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  BE_W  to memory byteenable.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_writedata  out  DATA_W  to memory writedata.
- mem_clken  out  1  to memory clken; tied to 1.
- mem_readdata  in  DATA_W  from memory readdata.

Behaviour:
- Reset (reset_n low, asynchronous):
  - if_rvalid = 0, d_rvalid = 0.
  - last_winner = DATA, so fetch wins the first contention.
  - lock_owner = 0, rd_tag = NONE.
  - if_gnt, d_gnt, mem_chipselect and mem_write are 0 while reset_n is low.
- Grant (combinational, one winner per cycle; none while freeze = 1):
  - lock_owner = 1 and d_req = 1: data wins.
  - lock_owner = 1 and d_req = 0: no grant; fetch is stalled.
  - Only one request present: that port wins.
  - Both present: the port that is not last_winner wins.
- Memory drive in the grant cycle:
  - mem_chipselect = 1.
  - mem_address = winner address.
  - mem_write = d_we only when data wins; fetch never writes.
  - mem_byteenable = d_be for a data write; all ones for any read.
  - mem_writedata = d_wdata.
  - When there is no grant: mem_chipselect = 0 and mem_write = 0; address and data are don't-care.
- Registered updates at each grant:
  - last_winner <= winner.
  - lock_owner <= d_gnt & d_lock. Lock clears on the first data grant with d_lock = 0, or when d_lock drops while d_req = 0.
- Read return:
  - The memory registers the address, so read data is valid on the cycle after the grant.
  - rd_tag records IF or D for a granted read, NONE otherwise.
  - Next cycle, if_rvalid or d_rvalid pulses for exactly one cycle and routes mem_readdata to that port's rdata.
  - Writes produce no rvalid.
- Pipelining:
  - A new grant may occur in the same cycle as the previous read's rvalid, giving full throughput of one access per cycle.
  - No state is kept beyond one outstanding read.
- Requester rules:
  - Requesters hold req, address and data stable until they see gnt.
  - rdata is don't-care when rvalid = 0.
- Freeze:
  - Blocks new grants only.
  - An rvalid already pending still fires.
  - lock_owner is unchanged.
- Reset mid-read: the pending rvalid is dropped.
- Address range: full 0..2^ADDR_W-1; no wrap handling is needed.

Test Plan:
- Fetch-only read: if_req = 1, if_addr = 0x0010, memory preloaded with 0xA5C3 → if_gnt on cycle 0; if_rvalid = 1 with if_rdata = 0xA5C3 on cycle 1 only; d_rvalid stays 0.
- Data write then read-back:
  - Write d_addr = 0x1234, d_be = 2'b01, d_wdata = 0xBEEF over existing word 0x0000 → mem_write high for one cycle.
  - Read 0x1234 → d_rdata = 0x00EF with d_rvalid one cycle after the grant.
- Contention after reset: if_req and d_req held high for 4 cycles → grant order IF, D, IF, D; each rvalid lands on the correct port one cycle after its grant.
- Lock burst:
  - d_lock = 1 for 3 data reads at 0x0100..0x0102 with if_req held high → three consecutive d_gnt, no if_gnt.
  - A 4th request with d_lock = 0 is granted, then if_gnt follows on the next cycle.
- Freeze: freeze = 1 for 3 cycles, one cycle after a granted fetch read → if_rvalid still fires; no gnt and mem_chipselect = 0 for 3 cycles; grants resume on the cycle freeze falls.
- Asynchronous reset: assert reset_n = 0 mid-cycle between a read grant and its return → all rvalid low immediately, no rvalid after release, and the first contention after release goes to IF.

Source files
------------

// File: rtl/imem_dmem_arbiter_if.sv
// Core-side and memory-side signals of the shared
// instruction/data memory arbiter.
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BE_W   = DATA_W / 8
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;

  logic              d_req;
  logic              d_we;
  logic              d_lock;
  logic [ADDR_W-1:0] d_addr;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_gnt,
    output if_rdata,
    output if_rvalid,
    input  d_req,
    input  d_we,
    input  d_lock,
    input  d_addr,
    input  d_be,
    input  d_wdata,
    output d_gnt,
    output d_rdata,
    output d_rvalid,
    output mem_address,
    output mem_byteenable,
    output mem_chipselect,
    output mem_write,
    output mem_writedata,
    output mem_clken,
    input  mem_readdata
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_gnt,
    input  if_rdata,
    input  if_rvalid,
    output d_req,
    output d_we,
    output d_lock,
    output d_addr,
    output d_be,
    output d_wdata,
    input  d_gnt,
    input  d_rdata,
    input  d_rvalid,
    input  mem_address,
    input  mem_byteenable,
    input  mem_chipselect,
    input  mem_write,
    input  mem_writedata,
    input  mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one single-port memory
// between instruction fetch and a lockable data port.
module imem_dmem_arbiter (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                freeze,
  imem_dmem_arbiter_if.slave  bus
);

  typedef enum logic {
    W_IF,
    W_D
  } win_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_IF,
    TAG_D
  } tag_e;

  win_e last_q, last_d;
  logic lock_q, lock_d;
  tag_e tag_q, tag_d;

  logic gnt_if;
  logic gnt_d;
  logic d_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= W_D;
      lock_q <= 1'b0;
      tag_q  <= TAG_NONE;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
      tag_q  <= tag_d;
    end
  end

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (reset_n && !freeze) begin
      unique case (1'b1)
        lock_q: begin
          gnt_d = bus.d_req;
        end
        !lock_q && bus.if_req && bus.d_req: begin
          gnt_if = (last_q == W_D);
          gnt_d  = (last_q == W_IF);
        end
        !lock_q && bus.if_req && !bus.d_req: begin
          gnt_if = 1'b1;
        end
        !lock_q && !bus.if_req && bus.d_req: begin
          gnt_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    lock_d = lock_q;
    tag_d  = TAG_NONE;
    if (gnt_if) begin
      last_d = W_IF;
      lock_d = 1'b0;
      tag_d  = TAG_IF;
    end else if (gnt_d) begin
      last_d = W_D;
      lock_d = bus.d_lock;
      tag_d  = bus.d_we ? TAG_NONE : TAG_D;
    end else if (lock_q && !freeze && !bus.d_lock) begin
      // owner released the lock while idle
      lock_d = 1'b0;
    end
  end

  assign d_wr = gnt_d & bus.d_we;

  always_comb begin
    bus.if_gnt         = gnt_if;
    bus.d_gnt          = gnt_d;
    bus.mem_chipselect = gnt_if | gnt_d;
    bus.mem_write      = d_wr;
    bus.mem_address    = gnt_d ? bus.d_addr
                               : bus.if_addr;
    bus.mem_byteenable = d_wr ? bus.d_be : '1;
    bus.mem_writedata  = bus.d_wdata;
    bus.mem_clken      = 1'b1;
    bus.if_rvalid      = (tag_q == TAG_IF);
    bus.d_rvalid       = (tag_q == TAG_D);
    bus.if_rdata       = bus.mem_readdata;
    bus.d_rdata        = bus.mem_readdata;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a memory
// model and a per-cycle reference model of arbitration.
module tb_imem_dmem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  logic freeze;

  always #5 clk = ~clk;

  imem_dmem_arbiter_if #(
    .ADDR_W(16),
    .DATA_W(16),
    .BE_W(2)
  ) bus ();

  imem_dmem_arbiter dut (
    .clk(clk),
    .reset_n(reset_n),
    .freeze(freeze),
    .bus(bus.slave)
  );

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t",
                  nm, act, exp, $time);
  endtask

  // Memory: registered read, byte-enabled write
  logic [15:0] mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_a;
  logic [15:0] pre_d;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write) begin
        if (bus.mem_byteenable[0])
          mem[bus.mem_address][7:0] <= bus.mem_writedata[7:0];
        if (bus.mem_byteenable[1])
          mem[bus.mem_address][15:8] <= bus.mem_writedata[15:8];
      end else begin
        bus.mem_readdata <= mem[bus.mem_address];
      end
    end
  end

  // Reference model
  logic [15:0] ref_mem [0:65535];
  logic        m_last_d;
  logic        m_lock;
  int          m_pend;
  logic [15:0] m_pdata;
  logic        eg_if;
  logic        eg_d;
  int          glog[$];

  always @(negedge clk) begin
    if (pre_we) ref_mem[pre_a] = pre_d;
    if (!reset_n) begin
      chk("rst if_gnt", bus.if_gnt, 0);
      chk("rst d_gnt", bus.d_gnt, 0);
      chk("rst cs", bus.mem_chipselect, 0);
      chk("rst we", bus.mem_write, 0);
      chk("rst if_rvalid", bus.if_rvalid, 0);
      chk("rst d_rvalid", bus.d_rvalid, 0);
      m_last_d = 1'b1;
      m_lock   = 1'b0;
      m_pend   = 0;
    end else begin
      eg_if = 1'b0;
      eg_d  = 1'b0;
      if (!freeze) begin
        if (m_lock) eg_d = bus.d_req;
        else if (bus.if_req && bus.d_req) begin
          if (m_last_d) eg_if = 1'b1;
          else eg_d = 1'b1;
        end else begin
          eg_if = bus.if_req;
          eg_d  = bus.d_req;
        end
      end
      chk("if_gnt", bus.if_gnt, eg_if);
      chk("d_gnt", bus.d_gnt, eg_d);
      chk("cs", bus.mem_chipselect, eg_if | eg_d);
      chk("mem_write", bus.mem_write, eg_d & bus.d_we);
      if (eg_if) begin
        chk("if addr", bus.mem_address, bus.if_addr);
        chk("if be", bus.mem_byteenable, 2'b11);
      end
      if (eg_d) begin
        chk("d addr", bus.mem_address, bus.d_addr);
        chk("d be", bus.mem_byteenable,
            bus.d_we ? bus.d_be : 2'b11);
        if (bus.d_we)
          chk("wdata", bus.mem_writedata, bus.d_wdata);
      end
      chk("if_rvalid", bus.if_rvalid, m_pend == 1);
      chk("d_rvalid", bus.d_rvalid, m_pend == 2);
      if (m_pend == 1) chk("if_rdata", bus.if_rdata, m_pdata);
      if (m_pend == 2) chk("d_rdata", bus.d_rdata, m_pdata);
      m_pend = 0;
      if (eg_if) begin
        glog.push_back(1);
        m_pend   = 1;
        m_pdata  = ref_mem[bus.if_addr];
        m_last_d = 1'b0;
        m_lock   = 1'b0;
      end else if (eg_d) begin
        glog.push_back(2);
        m_last_d = 1'b1;
        m_lock   = bus.d_lock;
        if (bus.d_we) begin
          if (bus.d_be[0])
            ref_mem[bus.d_addr][7:0] = bus.d_wdata[7:0];
          if (bus.d_be[1])
            ref_mem[bus.d_addr][15:8] = bus.d_wdata[15:8];
        end else begin
          m_pend  = 2;
          m_pdata = ref_mem[bus.d_addr];
        end
      end else if (m_lock && !freeze && !bus.d_lock) begin
        m_lock = 1'b0;
      end
    end
  end

  logic [15:0] pa [6];
  logic [15:0] pd [6];
  int          order [4];
  int          base;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
    bus.d_lock = 1'b0;
  endtask

  initial begin
    pa = '{16'h0010, 16'h1234, 16'h0100,
           16'h0101, 16'h0102, 16'h0103};
    pd = '{16'hA5C3, 16'h0000, 16'h1001,
           16'h1002, 16'h1003, 16'h1004};
    order = '{1, 2, 1, 2};
    reset_n = 1'b0;
    freeze  = 1'b0;
    pre_we  = 1'b0;
    pre_a   = 16'h0;
    pre_d   = 16'h0;
    idle();
    bus.if_addr = 16'h0;
    bus.d_addr  = 16'h0;
    bus.d_be    = 2'b00;
    bus.d_wdata = 16'h0;
    tick();
    for (int i = 0; i < 6; i++) begin
      pre_we = 1'b1;
      pre_a  = pa[i];
      pre_d  = pd[i];
      tick();
    end
    pre_we = 1'b0;
    chk("reset if_rvalid", bus.if_rvalid, 0);
    chk("reset d_rvalid", bus.d_rvalid, 0);
    chk("reset cs", bus.mem_chipselect, 0);
    reset_n = 1'b1;
    tick();

    // fetch-only read
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0010;
    #3 chk("t1 if_gnt", bus.if_gnt, 1);
    tick();
    idle();
    chk("t1 if_rvalid", bus.if_rvalid, 1);
    chk("t1 if_rdata", bus.if_rdata, 16'hA5C3);
    chk("t1 d_rvalid", bus.d_rvalid, 0);
    tick();
    chk("t1 if_rvalid off", bus.if_rvalid, 0);

    // byte write then read-back
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 16'h1234;
    bus.d_be = 2'b01;
    bus.d_wdata = 16'hBEEF;
    #3 chk("t2 wr gnt", bus.d_gnt, 1);
    chk("t2 mem_write", bus.mem_write, 1);
    tick();
    bus.d_we = 1'b0;
    bus.d_be = 2'b11;
    #3 chk("t2 rd gnt", bus.d_gnt, 1);
    chk("t2 mem_write off", bus.mem_write, 0);
    chk("t2 no wr rvalid", bus.d_rvalid, 0);
    tick();
    idle();
    chk("t2 d_rvalid", bus.d_rvalid, 1);
    chk("t2 d_rdata", bus.d_rdata, 16'h00EF);
    tick();

    // contention right after reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    base = glog.size();
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0010;
    bus.d_req = 1'b1;
    bus.d_addr = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) idle();
      chk("t3 if_rvalid", bus.if_rvalid, (i % 2) == 0);
      chk("t3 d_rvalid", bus.d_rvalid, (i % 2) == 1);
      chk("t3 rdata", bus.mem_readdata,
          (i % 2) == 0 ? 16'hA5C3 : 16'h00EF);
    end
    tick();
    chk("t3 grant count", glog.size(), base + 4);
    for (int i = 0; i < 4; i++)
      if (base + i < glog.size())
        chk("t3 grant order", glog[base + i], order[i]);

    // locked data burst
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0010;
    tick();
    idle();
    tick();
    bus.if_req = 1'b1;
    bus.d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.d_addr = 16'h0100 + 16'(k);
      bus.d_lock = (k < 3);
      #3 chk("t4 d_gnt", bus.d_gnt, 1);
      chk("t4 if_gnt", bus.if_gnt, 0);
      tick();
      chk("t4 d_rvalid", bus.d_rvalid, 1);
      chk("t4 d_rdata", bus.d_rdata, 16'h1001 + 16'(k));
    end
    bus.d_req = 1'b0;
    bus.d_lock = 1'b0;
    #3 chk("t4 if after unlock", bus.if_gnt, 1);
    tick();
    idle();
    chk("t4 if_rvalid", bus.if_rvalid, 1);
    tick();

    // freeze with a read in flight
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0010;
    #3 chk("t5 if_gnt", bus.if_gnt, 1);
    tick();
    freeze = 1'b1;
    bus.d_req = 1'b1;
    bus.d_addr = 16'h1234;
    chk("t5 rvalid in freeze", bus.if_rvalid, 1);
    chk("t5 rdata in freeze", bus.if_rdata, 16'hA5C3);
    for (int j = 0; j < 3; j++) begin
      #3 chk("t5 frz if_gnt", bus.if_gnt, 0);
      chk("t5 frz d_gnt", bus.d_gnt, 0);
      chk("t5 frz cs", bus.mem_chipselect, 0);
      tick();
      chk("t5 frz no rvalid", bus.if_rvalid, 0);
    end
    freeze = 1'b0;
    #3 chk("t5 resume d_gnt", bus.d_gnt, 1);
    tick();
    idle();
    chk("t5 d_rvalid", bus.d_rvalid, 1);
    chk("t5 d_rdata", bus.d_rdata, 16'h00EF);
    tick();

    // reset between grant and return
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0010;
    #3 chk("t6 if_gnt", bus.if_gnt, 1);
    #3 reset_n = 1'b0;
    #1 chk("t6 gnt in reset", bus.if_gnt, 0);
    chk("t6 cs in reset", bus.mem_chipselect, 0);
    idle();
    tick();
    chk("t6 if_rvalid dropped", bus.if_rvalid, 0);
    tick();
    reset_n = 1'b1;
    chk("t6 rvalid after rel", bus.if_rvalid, 0);
    tick();
    chk("t6 rvalid later", bus.if_rvalid | bus.d_rvalid, 0);
    bus.if_req = 1'b1;
    bus.d_req = 1'b1;
    bus.d_addr = 16'h1234;
    #3 chk("t6 first if_gnt", bus.if_gnt, 1);
    chk("t6 first d_gnt", bus.d_gnt, 0);
    tick();
    idle();
    chk("t6 if_rvalid", bus.if_rvalid, 1);
    tick();

    // reset clears a visible rvalid at once
    bus.if_req = 1'b1;
    tick();
    idle();
    #1 chk("t7 rvalid before", bus.if_rvalid, 1);
    reset_n = 1'b0;
    #1 chk("t7 rvalid cleared", bus.if_rvalid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t7 no rvalid", bus.if_rvalid | bus.d_rvalid, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
